// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM encoding, PC increment
// and the default reset address.
package pipeline_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Combinational redirect selection: branch/jump priority, target choice and
// word-alignment of the chosen target.
module fetch_redirect_sel #(
   parameter int N = 32
) (
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   input  logic         jump,
   input  logic [N-1:0] jump_target,
   output logic         redir,
   output logic [N-1:0] target
);

   logic [N-1:0] raw_target;

   // The branch is resolved in EX and so belongs to the older instruction;
   // it must win over a jump resolved in ID during the same cycle.
   always_comb begin
      redir      = branch_taken | jump;
      raw_target = branch_taken ? branch_target : jump_target;
      target     = {raw_target[N-1:2], 2'b00};
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with BOOT/RUN/PEND FSM that holds redirects across stalls.
// Optional FETCH_PC_REDIRECT_CNT_EN adds a saturating 16-bit redirect counter.
module fetch_pc_unit
   import pipeline_pkg::*;
#(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = DEFAULT_RESET_PC[N-1:0]
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   input  logic         jump,
   input  logic [N-1:0] jump_target,
   output logic [N-1:0] pc,
   output logic [N-1:0] pc_plus4,
   output logic         fetch_valid,
   output logic         redirect_flush
`ifdef FETCH_PC_REDIRECT_CNT_EN
   ,
   output logic [15:0]  redirect_cnt
`endif
);

   fetch_state_t state;
   logic [N-1:0] pend_pc;
   logic         redir;
   logic [N-1:0] target;

   fetch_redirect_sel #(.N(N)) u_sel (
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .redir        (redir),
      .target       (target)
   );

   assign pc_plus4 = pc + N'(INSTR_BYTES);

   // PEND parks a redirect that arrived under stall; a later redirect while
   // still stalled replaces it because it is the most recent decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= BOOT;
         pc             <= RESET_PC;
         pend_pc        <= '0;
         fetch_valid    <= 1'b0;
         redirect_flush <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state          <= RUN;
               fetch_valid    <= 1'b1;
               redirect_flush <= 1'b0;
            end
            RUN: begin
               if (!stall) begin
                  pc             <= redir ? target : pc_plus4;
                  redirect_flush <= redir;
               end else if (redir) begin
                  pend_pc        <= target;
                  state          <= PEND;
                  fetch_valid    <= 1'b0;
                  redirect_flush <= 1'b1;
               end else begin
                  redirect_flush <= 1'b0;
               end
            end
            PEND: begin
               if (stall) begin
                  if (redir) begin
                     pend_pc <= target;
                  end
                  redirect_flush <= redir;
               end else begin
                  pc             <= redir ? target : pend_pc;
                  state          <= RUN;
                  fetch_valid    <= 1'b1;
                  redirect_flush <= redir;
               end
            end
            default: begin
               state          <= BOOT;
               pc             <= RESET_PC;
               fetch_valid    <= 1'b0;
               redirect_flush <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PC_REDIRECT_CNT_EN
   // Counts flush cycles, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_cnt <= 16'h0000;
      end else if (redirect_flush && (redirect_cnt != 16'hFFFF)) begin
         redirect_cnt <= redirect_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard-driven bench for fetch_pc_unit; FETCH_PC_REDIRECT_CNT_EN also
// checks the redirect counter.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        redirect_flush;
`ifdef FETCH_PC_REDIRECT_CNT_EN
   logic [15:0] redirect_cnt;
`endif

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        fl;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int n_checks = 0;
   int n_fails  = 0;

   // Independent reference of the fetch behaviour.
   int          m_state;
   logic [31:0] m_pc, m_pend;
   logic        m_fv, m_fl;
   logic [15:0] m_cnt;

   fetch_pc_unit #(.N(32), .RESET_PC(32'h0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_valid   (fetch_valid),
      .redirect_flush(redirect_flush)
`ifdef FETCH_PC_REDIRECT_CNT_EN
      ,
      .redirect_cnt  (redirect_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0;
      m_pc    = 32'h0;
      m_pend  = 32'h0;
      m_fv    = 1'b0;
      m_fl    = 1'b0;
      m_cnt   = 16'h0;
      sb.delete();
   endtask

   // Drives one cycle of stimulus, predicts the post-edge outputs and queues
   // them, then advances to just after the rising edge.
   task automatic applyStimulus(input logic s, input logic br, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt);
      logic        r;
      logic [31:0] t;
      exp_t        x;
      stall = s; branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
      r = br | j;
      t = (br ? bt : jt) & 32'hFFFF_FFFC;
      if (m_fl && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      case (m_state)
         0: begin m_state = 1; m_fv = 1'b1; m_fl = 1'b0; end
         1: begin
            if (!s) begin m_pc = r ? t : m_pc + 32'd4; m_fl = r; end
            else if (r) begin m_pend = t; m_state = 2; m_fv = 1'b0; m_fl = 1'b1; end
            else m_fl = 1'b0;
         end
         default: begin
            if (s) begin if (r) m_pend = t; m_fl = r; end
            else begin m_pc = r ? t : m_pend; m_state = 1; m_fv = 1'b1; m_fl = r; end
         end
      endcase
      x.pc = m_pc; x.fv = m_fv; x.fl = m_fl; x.cnt = m_cnt;
      sb.push_back(x);
      @(posedge clk);
      #1;
      stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] pc_tbl [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks += 3;
      if (pc !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
      if (fetch_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_fv got %b want 0", fetch_valid); end
      if (redirect_flush !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_flush got %b want 0", redirect_flush); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         e = sb.pop_front();
         n_checks += 5;
         if (pc !== e.pc) begin n_fails++; $display("[TB] FAIL boot_pc[%0d] got %h want %h", i, pc, e.pc); end
         if (pc !== pc_tbl[i]) begin n_fails++; $display("[TB] FAIL boot_seq[%0d] got %h want %h", i, pc, pc_tbl[i]); end
         if (pc_plus4 !== e.pc + 32'd4) begin n_fails++; $display("[TB] FAIL boot_pc4[%0d] got %h want %h", i, pc_plus4, e.pc + 32'd4); end
         if (fetch_valid !== e.fv) begin n_fails++; $display("[TB] FAIL boot_fv[%0d] got %b want %b", i, fetch_valid, e.fv); end
         if (redirect_flush !== e.fl) begin n_fails++; $display("[TB] FAIL boot_flush[%0d] got %b want %b", i, redirect_flush, e.fl); end
      end
   endtask

   // Shared by the scenario tasks: compares one cycle's outputs to the queue head.
   task automatic checkOutput(input string tag);
      e = sb.pop_front();
      n_checks += 4;
      if (pc !== e.pc) begin n_fails++; $display("[TB] FAIL %s_pc got %h want %h", tag, pc, e.pc); end
      if (pc_plus4 !== e.pc + 32'd4) begin n_fails++; $display("[TB] FAIL %s_pc4 got %h want %h", tag, pc_plus4, e.pc + 32'd4); end
      if (fetch_valid !== e.fv) begin n_fails++; $display("[TB] FAIL %s_fv got %b want %b", tag, fetch_valid, e.fv); end
      if (redirect_flush !== e.fl) begin n_fails++; $display("[TB] FAIL %s_flush got %b want %b", tag, redirect_flush, e.fl); end
`ifdef FETCH_PC_REDIRECT_CNT_EN
      n_checks++;
      if (redirect_cnt !== e.cnt) begin n_fails++; $display("[TB] FAIL %s_cnt got %0d want %0d", tag, redirect_cnt, e.cnt); end
`endif
   endtask

   task automatic test_branch_priority();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("prio_pre");
      n_checks++;
      if (pc !== 32'h10) begin n_fails++; $display("[TB] FAIL prio_start got %h want %h", pc, 32'h10); end
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 32'h200);
      checkOutput("prio_hit");
      n_checks += 2;
      if (pc !== 32'h100) begin n_fails++; $display("[TB] FAIL prio_target got %h want %h", pc, 32'h100); end
      if (redirect_flush !== 1'b1) begin n_fails++; $display("[TB] FAIL prio_pulse got %b want 1", redirect_flush); end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("prio_post");
      n_checks++;
      if (redirect_flush !== 1'b0) begin n_fails++; $display("[TB] FAIL prio_pulse_end got %b want 0", redirect_flush); end
   endtask

   task automatic test_stall_redirect();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
      checkOutput("stall_c1");
      n_checks += 2;
      if (fetch_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL stall_fv got %b want 0", fetch_valid); end
      if (pc !== 32'h104) begin n_fails++; $display("[TB] FAIL stall_hold got %h want %h", pc, 32'h104); end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         checkOutput("stall_hold");
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("stall_rel");
      n_checks += 2;
      if (pc !== 32'h40) begin n_fails++; $display("[TB] FAIL stall_release_pc got %h want %h", pc, 32'h40); end
      if (fetch_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL stall_release_fv got %b want 1", fetch_valid); end
   endtask

   task automatic test_pend_overwrite();
      int bad_fetch = 0;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
      checkOutput("ovr_c1");
      applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
      checkOutput("ovr_c2");
      if (fetch_valid === 1'b1 && pc === 32'h40) bad_fetch++;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("ovr_c3");
      if (fetch_valid === 1'b1 && pc === 32'h40) bad_fetch++;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("ovr_rel");
      n_checks += 2;
      if (pc !== 32'h80) begin n_fails++; $display("[TB] FAIL ovr_pc got %h want %h", pc, 32'h80); end
      if (bad_fetch !== 0) begin n_fails++; $display("[TB] FAIL ovr_stale got %0d fetches want 0", bad_fetch); end
   endtask

   task automatic test_wrap_align();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
      checkOutput("wrap_jmp");
      n_checks += 2;
      if (pc !== 32'hFFFF_FFFC) begin n_fails++; $display("[TB] FAIL wrap_pc got %h want %h", pc, 32'hFFFF_FFFC); end
      if (pc_plus4 !== 32'h0) begin n_fails++; $display("[TB] FAIL wrap_pc4 got %h want %h", pc_plus4, 32'h0); end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("wrap_next");
      n_checks++;
      if (pc !== 32'h0) begin n_fails++; $display("[TB] FAIL wrap_next got %h want %h", pc, 32'h0); end
      applyStimulus(1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
      checkOutput("align");
      n_checks++;
      if (pc !== 32'h100) begin n_fails++; $display("[TB] FAIL align_pc got %h want %h", pc, 32'h100); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] tgt [3] = '{32'h300, 32'h400, 32'h500};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, i[0], tgt[i], ~i[0], tgt[i]);
         checkOutput("b2b");
         n_checks++;
         if (pc !== tgt[i]) begin n_fails++; $display("[TB] FAIL b2b_pc[%0d] got %h want %h", i, pc, tgt[i]); end
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("b2b_end");
   endtask

   task automatic test_async_reset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
      checkOutput("ar_pend");
      #3;
      rst_n = 1'b0;
      #1;
      n_checks += 3;
      if (pc !== 32'h0) begin n_fails++; $display("[TB] FAIL ar_pc got %h want %h", pc, 32'h0); end
      if (fetch_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL ar_fv got %b want 0", fetch_valid); end
      if (redirect_flush !== 1'b0) begin n_fails++; $display("[TB] FAIL ar_flush got %b want 0", redirect_flush); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
      checkOutput("ar_boot");
      n_checks += 2;
      if (pc !== 32'h0) begin n_fails++; $display("[TB] FAIL ar_first_pc got %h want %h", pc, 32'h0); end
      if (fetch_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL ar_first_fv got %b want 1", fetch_valid); end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("ar_run");
      n_checks++;
      if (pc !== 32'h4) begin n_fails++; $display("[TB] FAIL ar_second_pc got %h want %h", pc, 32'h4); end
   endtask

   initial begin
      test_reset();
      test_branch_priority();
      test_stall_redirect();
      test_pend_overwrite();
      test_wrap_align();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
